// File: rtl/zap_event_pkg.sv
// Shared constants and the per-line sensitivity encoding for the event detector.
package zap_event_pkg;

    localparam int CNT_W      = 8;
    localparam int FILTER_MAX = 255;

    typedef enum logic {
        LEVEL = 1'b0,
        EDGE  = 1'b1
    } line_mode_e;

endpackage

// File: rtl/zap_glitch_filter.sv
// One event line: stability counter plus filtered level register.
// o_rise flags that the upcoming edge accepts a 0->1 transition.
module zap_glitch_filter
    import zap_event_pkg::*;
#(
    parameter int FILTER_CYCLES = 4
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_sync,
    output logic o_level,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(FILTER_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             accept;

    // The terminal compare bounds the counter, so it can never wrap.
    always_comb begin
        accept  = (i_sync != level_q) && (cnt_q == TERM);
        level_d = level_q;
        cnt_d   = '0;
        if (accept) begin
            level_d = i_sync;
        end else if (i_sync != level_q) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = accept & i_sync;

endmodule

// File: rtl/zap_sync_event_detector.sv
// Filtered event detector with sticky pending flags and a registered interrupt.
// Define ZAP_EVENT_OVERFLOW_EN to add the sticky o_overflow output.
module zap_sync_event_detector
    import zap_event_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [WIDTH-1:0] i_sync,
    input  logic [WIDTH-1:0] i_edge_mode,
    input  logic [WIDTH-1:0] i_clear,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_level,
    output logic [WIDTH-1:0] o_pending,
    output logic             o_irq
`ifdef ZAP_EVENT_OVERFLOW_EN
    ,
    output logic [WIDTH-1:0] o_overflow
`endif
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             irq_q, irq_d;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_line
            zap_glitch_filter #(
                .FILTER_CYCLES(FILTER_CYCLES)
            ) u_filter (
                .i_clk    (i_clk),
                .i_reset_n(i_reset_n),
                .i_sync   (i_sync[gi]),
                .o_level  (level[gi]),
                .o_rise   (rise[gi])
            );

            // Level mode keys off the level already held, not the one being accepted.
            assign set[gi] = (line_mode_e'(i_edge_mode[gi]) == EDGE) ? rise[gi] : level[gi];
        end
    endgenerate

    always_comb begin
        pending_d = set | (pending_q & ~i_clear);
        irq_d     = |(pending_q & i_mask);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    assign o_level   = level;
    assign o_pending = pending_q;
    assign o_irq     = irq_q;

`ifdef ZAP_EVENT_OVERFLOW_EN
    logic [WIDTH-1:0] overflow_q, overflow_d;

    always_comb begin
        overflow_d = (set & pending_q) | (overflow_q & ~i_clear);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign o_overflow = overflow_q;
`endif

endmodule

// File: tb/tb_zap_sync_event_detector.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_zap_sync_event_detector;

    localparam int W  = 4;
    localparam int FC = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] sync, mode, clr, mask;
    logic [W-1:0] level, pending;
    logic         irq;
    logic [W-1:0] ovf;

    always #5 clk = ~clk;

    zap_sync_event_detector #(
        .WIDTH        (W),
        .FILTER_CYCLES(FC)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_sync     (sync),
        .i_edge_mode(mode),
        .i_clear    (clr),
        .i_mask     (mask),
        .o_level    (level),
        .o_pending  (pending),
        .o_irq      (irq)
`ifdef ZAP_EVENT_OVERFLOW_EN
        ,
        .o_overflow (ovf)
`endif
    );

`ifndef ZAP_EVENT_OVERFLOW_EN
    assign ovf = '0;
`endif

    typedef struct packed {
        logic [W-1:0] level;
        logic [W-1:0] pend;
        logic         irq;
        logic [W-1:0] ovf;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a line flips once the last FC samples all disagree with it.
    logic [W-1:0]  m_level, m_pend, m_ovf;
    logic          m_irq;
    logic [FC-1:0] hist [W];
    int            fill [W];

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_level = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_irq   = 1'b0;
        for (int l = 0; l < W; l++) begin
            hist[l] = '0;
            fill[l] = 0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0]  old_pend;
        logic [FC-1:0] want;
        logic          old, set;
        old_pend = m_pend;
        for (int l = 0; l < W; l++) begin
            old     = m_level[l];
            hist[l] = {hist[l][FC-2:0], sync[l]};
            if (fill[l] < FC) fill[l]++;
            want = old ? {FC{1'b0}} : {FC{1'b1}};
            if (fill[l] == FC && hist[l] == want) m_level[l] = ~old;
            set = mode[l] ? (!old && m_level[l]) : old;
            m_ovf[l]  = (set && old_pend[l]) || (m_ovf[l] && !clr[l]);
            m_pend[l] = set || (old_pend[l] && !clr[l]);
        end
        m_irq = |(old_pend & mask);
    endtask

    task automatic drive_cycle(input logic rn, input logic [W-1:0] s, input logic [W-1:0] md,
                               input logic [W-1:0] c, input logic [W-1:0] mk);
        exp_t e;
        sync = s;
        mode = md;
        clr  = c;
        mask = mk;
        if (!rn && rst_n) begin
            #2 rst_n = 1'b0;
            #1;
            chk("async_rst_level", level, '0);
            chk("async_rst_pending", pending, '0);
            chk("async_rst_irq", {3'b000, irq}, '0);
            chk("async_rst_ovf", ovf, '0);
        end else begin
            rst_n = rn;
        end
        if (!rn) model_reset();
        else model_step();
        e.level = m_level;
        e.pend  = m_pend;
        e.irq   = m_irq;
        e.ovf   = m_ovf;
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("level", level, e.level);
            chk("pending", pending, e.pend);
            chk("irq", {3'b000, irq}, {3'b000, e.irq});
`ifdef ZAP_EVENT_OVERFLOW_EN
            chk("overflow", ovf, e.ovf);
`endif
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    localparam logic [W-1:0] E = 4'b1111;

    initial begin
        logic [W-1:0] s, md, c, mk;
        int           hold [W];
        logic         rn;
        int           rst_left;

        rst_n = 1'b0;
        sync  = '0;
        mode  = E;
        clr   = '0;
        mask  = '0;
        model_reset();
        @(negedge clk);

        repeat (3) drive_cycle(1'b0, 4'b0000, E, 4'b0000, 4'b0010);

        // Three-cycle glitch on line 0 must be swallowed.
        repeat (3) drive_cycle(1'b1, 4'b0001, E, 4'b0000, 4'b0010);
        repeat (5) drive_cycle(1'b1, 4'b0000, E, 4'b0000, 4'b0010);

        // Line 1 rises and holds; irq follows pending by one cycle.
        repeat (6) drive_cycle(1'b1, 4'b0010, E, 4'b0000, 4'b0010);

        // Line 2: clear coinciding with an accepted rise keeps pending, then a lone clear drops it.
        repeat (6) drive_cycle(1'b1, 4'b0110, E, 4'b0000, 4'b0010);
        repeat (6) drive_cycle(1'b1, 4'b0010, E, 4'b0000, 4'b0010);
        repeat (3) drive_cycle(1'b1, 4'b0110, E, 4'b0000, 4'b0010);
        drive_cycle(1'b1, 4'b0110, E, 4'b0100, 4'b0010);
        repeat (2) drive_cycle(1'b1, 4'b0110, E, 4'b0000, 4'b0010);
        drive_cycle(1'b1, 4'b0110, E, 4'b0100, 4'b0010);
        repeat (2) drive_cycle(1'b1, 4'b0110, E, 4'b0000, 4'b0010);

        // Line 3 in level mode: clear ignored while high, honoured after it falls.
        repeat (6) drive_cycle(1'b1, 4'b1110, 4'b0111, 4'b0000, 4'b1111);
        drive_cycle(1'b1, 4'b1110, 4'b0111, 4'b1000, 4'b1111);
        repeat (2) drive_cycle(1'b1, 4'b1110, 4'b0111, 4'b0000, 4'b1111);
        repeat (4) drive_cycle(1'b1, 4'b0110, 4'b0111, 4'b0000, 4'b1111);
        drive_cycle(1'b1, 4'b0110, 4'b0111, 4'b1000, 4'b1111);
        repeat (2) drive_cycle(1'b1, 4'b0110, 4'b0111, 4'b0000, 4'b1111);

        // All lines pending, reset mid-count, then lines already high at release.
        repeat (6) drive_cycle(1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
        repeat (2) drive_cycle(1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        drive_cycle(1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        drive_cycle(1'b0, 4'b1111, E, 4'b0000, 4'b1111);
        repeat (6) drive_cycle(1'b1, 4'b1111, E, 4'b0000, 4'b1111);

        // Randomized traffic: per-line hold lengths mix glitches and accepted changes.
        s        = 4'b1111;
        md       = 4'($urandom);
        mk       = 4'($urandom);
        rst_left = 0;
        for (int l = 0; l < W; l++) hold[l] = 1;
        for (int n = 0; n < 1500; n++) begin
            for (int l = 0; l < W; l++) begin
                hold[l]--;
                if (hold[l] <= 0) begin
                    s[l]    = ~s[l];
                    hold[l] = int'($urandom_range(1, 7));
                end
                c[l] = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 31) == 0) md = 4'($urandom);
            if ($urandom_range(0, 15) == 0) mk = 4'($urandom);
            if (rst_left == 0 && $urandom_range(0, 199) == 0) rst_left = int'($urandom_range(1, 3));
            rn = (rst_left == 0);
            if (rst_left > 0) rst_left--;
            drive_cycle(rn, s, md, c, mk);
        end

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 4'(q.size()), 4'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zap_sync_event_detector.md
ZAP_SYNC_EVENT_DETECTOR -- requirements
Module: zap_sync_event_detector

Interface
REQ-001 Parameter WIDTH, default 4: number of independent event lines.
REQ-002 Parameter FILTER_CYCLES, default 4, legal range 1..255: consecutive stable cycles required before a level change is accepted.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset_n  input  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is already synchronized by the system.
REQ-005 i_sync  input  WIDTH  already-synchronized event lines, output of the dual-rank synchronizer stage.
REQ-006 i_edge_mode  input  WIDTH  per line: 1 = rising-edge sensitive, 0 = level (high) sensitive.
REQ-007 i_clear  input  WIDTH  per line, write-1-to-clear pending, single-cycle strobe.
REQ-008 i_mask  input  WIDTH  per line: 1 = enabled into o_irq.
REQ-009 o_level  output  WIDTH  filtered, registered line level.
REQ-010 o_pending  output  WIDTH  sticky pending flags.
REQ-011 o_irq  output  1  registered OR of (o_pending & i_mask).

Function
REQ-012 Per line, an 8-bit stability counter increments each cycle i_sync differs from o_level and clears to 0 each cycle they are equal.
REQ-013 When i_sync differs from o_level and the counter equals FILTER_CYCLES-1, o_level takes i_sync and the counter clears to 0 at that edge.
REQ-014 Latency: a change held stable for FILTER_CYCLES cycles appears on o_level at the FILTER_CYCLES-th rising edge; with FILTER_CYCLES=1, o_level follows i_sync by one cycle.
REQ-015 A pulse shorter than FILTER_CYCLES cycles does not change o_level and produces no event.
REQ-016 Edge mode: pending sets at the same edge o_level accepts a 0->1 transition; 1->0 transitions produce no event.
REQ-017 Level mode: pending sets at every edge where o_level is 1.
REQ-018 Pending clears at the edge following an i_clear strobe for that line.
REQ-019 Simultaneous set and clear on the same line in the same cycle: set wins, pending remains 1.
REQ-020 In level mode, i_clear while o_level is 1 leaves pending at 1.
REQ-021 A change of i_edge_mode takes effect on the next evaluation edge; it neither sets nor clears pending.
REQ-022 o_irq is registered: it reflects o_pending & i_mask of the previous cycle, one cycle after pending changes.
REQ-023 Counters never wrap; the FILTER_CYCLES-1 terminal condition bounds them.

Reset
REQ-024 While i_reset_n is 0: o_level, o_pending, and all counters are 0, and o_irq is 0, independent of i_clk.
REQ-025 Reset asserted mid-filtering discards partial counts; a line already at 1 at reset release must be stable for FILTER_CYCLES cycles before o_level rises and, in edge mode, raises pending.

Configuration
REQ-026 Macro ZAP_EVENT_OVERFLOW_EN, when defined, adds output o_overflow [WIDTH]: sticky, set when a line's set condition fires while its pending is already 1, cleared by the same i_clear strobe, and reset to 0.
REQ-027 Without ZAP_EVENT_OVERFLOW_EN, the port and its logic are absent, and all other behaviour is identical.

Structure
REQ-028 Package zap_event_pkg holds the counter width constant (8), the FILTER_CYCLES legal maximum (255), and the typedef for the per-line mode encoding (EDGE, LEVEL).
REQ-029 The per-line counter and level register form sub-module zap_glitch_filter, instantiated WIDTH times via generate; pending and irq logic stay in the top.

Verification
REQ-030 FILTER_CYCLES=4; line0 at 1 for 3 cycles then 0 -> o_level[0] stays 0, o_pending[0] stays 0.
REQ-031 FILTER_CYCLES=4, edge mode; line1 rises and holds -> o_level[1]=1 and o_pending[1]=1 at the 4th edge; o_irq=1 one cycle later with i_mask=4'b0010.
REQ-032 Edge mode, pending[2]=1; i_clear[2] coincides with a new accepted rising edge -> o_pending[2] stays 1; a later i_clear alone -> 0.
REQ-033 Level mode, line3 held high, i_clear[3] pulsed -> o_pending[3] stays 1; line3 low for 4 cycles then i_clear -> 0.
REQ-034 i_reset_n driven low asynchronously mid-count with pending=4'b1111 -> all outputs read 0 before the next i_clk edge.
REQ-035 With ZAP_EVENT_OVERFLOW_EN, two accepted rising edges on line0 without a clear -> o_overflow[0]=1, and i_clear[0] -> o_overflow[0]=0 and o_pending[0]=0.
